// File: rtl/j1_io_pkg.sv
// Shared definitions for the J1 I/O fabric.
// Contents:
//   - MAX_SLOTS : upper bound on peripheral slots.
//   - ST_*      : offsets of the fabric's registers inside its status page.
//   - ERR_*     : bit positions inside the ERR register.
package j1_io_pkg;

  localparam int unsigned MAX_SLOTS = 8;

  localparam logic [7:0] ST_ERR     = 8'd0;
  localparam logic [7:0] ST_BADADDR = 8'd1;
  localparam logic [7:0] ST_ACCCNT  = 8'd2;
  localparam logic [7:0] ST_ENMASK  = 8'd3;

  localparam int unsigned ERR_URD   = 0;
  localparam int unsigned ERR_UWR   = 1;
  localparam int unsigned ERR_MULTI = 2;
  localparam int unsigned ERR_W     = 3;

endpackage

// File: rtl/j1_io_status_regs.sv
// Fabric status page: ERR (write-1-to-clear flags), BADADDR, ACCCNT, ENMASK.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   st_wr       : CPU write to the status page (already qualified)
//   st_off      : offset inside the status page
//   wdata       : CPU write data
//   set_urd     : unmapped read this cycle
//   set_uwr     : unmapped write this cycle
//   set_multi   : strobed access that hit more than one slot
//   cnt_inc     : strobed access that hit a slot
//   bad_addr    : address captured on an unmapped access
//   en_mask     : slot-enable mask
//   rdata       : read data for st_off (current, pre-update values)
module j1_io_status_regs
  import j1_io_pkg::*;
#(
  parameter int unsigned N_SLOTS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_wr,
  input  logic [7:0]         st_off,
  input  logic [15:0]        wdata,
  input  logic               set_urd,
  input  logic               set_uwr,
  input  logic               set_multi,
  input  logic               cnt_inc,
  input  logic [15:0]        bad_addr,
  output logic [N_SLOTS-1:0] en_mask,
  output logic [15:0]        rdata
);

  logic [ERR_W-1:0] err;
  logic [ERR_W-1:0] err_set;
  logic [ERR_W-1:0] err_clr;
  logic [15:0]      badaddr;
  logic [15:0]      acccnt;
  logic             unused_wdata;

  // Only the low bits of wdata matter for ERR and ENMASK.
  assign unused_wdata = ^wdata;

  always_comb begin
    err_set            = '0;
    err_set[ERR_URD]   = set_urd;
    err_set[ERR_UWR]   = set_uwr;
    err_set[ERR_MULTI] = set_multi;
    err_clr            = '0;
    if (st_wr && st_off == ST_ERR) err_clr = wdata[ERR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= '0;
      badaddr <= '0;
      acccnt  <= '0;
      en_mask <= '1;
    end else begin
      // Set is applied after clear so a coincident event is never lost.
      err <= (err & ~err_clr) | err_set;
      if (set_urd || set_uwr) badaddr <= bad_addr;
      if (st_wr && st_off == ST_ACCCNT) acccnt <= '0;
      else if (cnt_inc && acccnt != 16'hFFFF) acccnt <= acccnt + 16'd1;
      if (st_wr && st_off == ST_ENMASK) en_mask <= wdata[N_SLOTS-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (st_off)
      ST_ERR:     rdata = {{(16-ERR_W){1'b0}}, err};
      ST_BADADDR: rdata = badaddr;
      ST_ACCCNT:  rdata = acccnt;
      ST_ENMASK:  rdata = {{(16-N_SLOTS){1'b0}}, en_mask};
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/j1_io_fabric.sv
// I/O interconnect between the J1 core and N_SLOTS memory-mapped peripherals.
// Decodes j1_io_addr[15:8] against a per-slot page table (lowest slot wins),
// forwards strobes combinationally, muxes read data back (combinational or
// registered) and hosts a local status page at STATUS_PAGE.
// Ports:
//   sys_clk_i, sys_rst_i : clock, synchronous active-high reset
//   j1_io_rd/wr/addr/dout: CPU side strobes, address, write data
//   j1_io_din            : read data to CPU
//   per_cs               : one-hot chip select of the winning slot
//   per_addr             : local address bits
//   per_rd, per_wr       : forwarded strobes (only when a slot hits)
//   per_din              : write data to peripherals
//   per_dout             : packed read data, slot i at [16i+15:16i]
module j1_io_fabric
  import j1_io_pkg::*;
#(
  parameter int unsigned           N_SLOTS     = 4,
  parameter logic [8*N_SLOTS-1:0]  SLOT_PAGES  = {8'h00, 8'h00, 8'h77, 8'h99},
  parameter int unsigned           LOCAL_AW    = 4,
  parameter logic [7:0]            STATUS_PAGE = 8'hFE,
  parameter bit                    READ_REG    = 1'b1
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_rst_i,
  input  logic                    j1_io_rd,
  input  logic                    j1_io_wr,
  input  logic [15:0]             j1_io_addr,
  input  logic [15:0]             j1_io_dout,
  output logic [15:0]             j1_io_din,
  output logic [N_SLOTS-1:0]      per_cs,
  output logic [LOCAL_AW-1:0]     per_addr,
  output logic                    per_rd,
  output logic                    per_wr,
  output logic [15:0]             per_din,
  input  logic [16*N_SLOTS-1:0]   per_dout
);

  logic [7:0]         page;
  logic               st_sel;
  logic               live;
  logic [N_SLOTS-1:0] en_mask;
  logic [N_SLOTS-1:0] hit;
  logic [N_SLOTS-1:0] win;
  logic [N_SLOTS:0]   found;
  logic [15:0]        rd_chain [0:N_SLOTS];
  logic               any_hit;
  logic               multi;
  logic               any_strobe;
  logic               unmapped;
  logic [15:0]        st_rdata;
  logic [15:0]        rd_mux;

  assign page   = j1_io_addr[15:8];
  assign st_sel = (page == STATUS_PAGE);
  assign live   = ~sys_rst_i;

  assign found[0]    = 1'b0;
  assign rd_chain[0] = '0;

  // The status page takes precedence over any slot mapped to the same page.
  // found[] ripples upward so only the lowest hitting slot is selected.
  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    assign hit[i]        = (page == SLOT_PAGES[8*i +: 8]) && en_mask[i] && !st_sel;
    assign win[i]        = hit[i] && !found[i];
    assign found[i+1]    = found[i] | hit[i];
    assign rd_chain[i+1] = rd_chain[i] | ({16{win[i]}} & per_dout[16*i +: 16]);
  end

  assign any_hit    = found[N_SLOTS];
  assign multi      = |(hit & ~win);
  assign any_strobe = (j1_io_rd | j1_io_wr) & live;
  assign unmapped   = !any_hit && !st_sel;

  assign per_cs   = win;
  assign per_addr = j1_io_addr[LOCAL_AW-1:0];
  assign per_rd   = j1_io_rd & any_hit & live;
  assign per_wr   = j1_io_wr & any_hit & live;
  assign per_din  = j1_io_dout;

  j1_io_status_regs #(
    .N_SLOTS (N_SLOTS)
  ) u_status (
    .clk       (sys_clk_i),
    .rst       (sys_rst_i),
    .st_wr     (j1_io_wr & st_sel & live),
    .st_off    (j1_io_addr[7:0]),
    .wdata     (j1_io_dout),
    .set_urd   (j1_io_rd & unmapped & live),
    .set_uwr   (j1_io_wr & unmapped & live),
    .set_multi (any_strobe & multi),
    .cnt_inc   (any_strobe & any_hit),
    .bad_addr  (j1_io_addr),
    .en_mask   (en_mask),
    .rdata     (st_rdata)
  );

  // Unmapped addresses fall through to rd_chain[N_SLOTS], which is zero.
  assign rd_mux = st_sel ? st_rdata : rd_chain[N_SLOTS];

  if (READ_REG) begin : g_rreg
    logic [15:0] din_q;
    always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i)     din_q <= '0;
      else if (j1_io_rd) din_q <= rd_mux;
    end
    assign j1_io_din = din_q;
  end else begin : g_rcomb
    assign j1_io_din = rd_mux;
  end

endmodule

// File: tb/tb_j1_io_fabric.sv
// Directed, table-driven bench for j1_io_fabric with default parameters.
module tb_j1_io_fabric;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [15:0] addr, dout;
  logic [15:0] din;
  logic [3:0]  per_cs;
  logic [3:0]  per_addr;
  logic        per_rd, per_wr;
  logic [15:0] per_din;
  logic [63:0] per_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  j1_io_fabric dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (rst),
    .j1_io_rd   (rd),
    .j1_io_wr   (wr),
    .j1_io_addr (addr),
    .j1_io_dout (dout),
    .j1_io_din  (din),
    .per_cs     (per_cs),
    .per_addr   (per_addr),
    .per_rd     (per_rd),
    .per_wr     (per_wr),
    .per_din    (per_din),
    .per_dout   (per_dout)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  e_cs;
    logic        e_prd;
    logic        e_pwr;
    logic [15:0] e_din;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, w, input logic [15:0] a, d,
                             input logic [3:0] cs, input logic prd, pwr,
                             input logic [15:0] edin);
    vec_t t;
    t.rd = r; t.wr = w; t.addr = a; t.data = d;
    t.e_cs = cs; t.e_prd = prd; t.e_pwr = pwr; t.e_din = edin;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // One CPU access: drive at negedge, sample forwarding mid-cycle, then
  // drop strobes at the next negedge and sample j1_io_din there.
  task automatic do_op(input logic r, w, input logic [15:0] a, d,
                       output logic [3:0] cs, output logic prd, pwr,
                       output logic [3:0] pa, output logic [15:0] pdin,
                       output logic [15:0] din_after);
    @(negedge clk);
    rd = r; wr = w; addr = a; dout = d;
    #1;
    cs = per_cs; prd = per_rd; pwr = per_wr; pa = per_addr; pdin = per_din;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    #1;
    din_after = din;
  endtask

  task automatic op_chk(input string name, input int idx, input logic r, w,
                        input logic [15:0] a, d, input logic [15:0] edin);
    logic [3:0]  cs, pa;
    logic        prd, pwr;
    logic [15:0] pdin, dn;
    do_op(r, w, a, d, cs, prd, pwr, pa, pdin, dn);
    chk(name, idx, dn, edin);
  endtask

  initial begin
    logic [3:0]  cs, pa;
    logic        prd, pwr;
    logic [15:0] pdin, dn;

    per_dout = {16'hD333, 16'hC222, 16'hBEEF, 16'hA000};
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0000; dout = 16'h0000;

    // Reset state, with a read of a mapped slot held during reset.
    repeat (2) @(negedge clk);
    rd = 1'b1; addr = 16'h7700;
    #1;
    chk("rst_per_rd", 0, {15'b0, per_rd}, 16'h0000);
    @(negedge clk);
    rd = 1'b0; rst = 1'b0;
    #1;
    chk("rst_din", 0, din, 16'h0000);

    //       rd wr addr      data      cs    prd pwr din-after
    vecs.push_back(v(0, 1, 16'h9902, 16'h1234, 4'b0001, 0, 1, 16'h0000));
    vecs.push_back(v(1, 0, 16'h7705, 16'h0000, 4'b0010, 1, 0, 16'hBEEF));
    vecs.push_back(v(0, 1, 16'h7701, 16'h5555, 4'b0010, 0, 1, 16'hBEEF));
    vecs.push_back(v(1, 0, 16'h4000, 16'h0000, 4'b0000, 0, 0, 16'h0000));
    vecs.push_back(v(1, 0, 16'hFE00, 16'h0000, 4'b0000, 0, 0, 16'h0001));
    vecs.push_back(v(1, 0, 16'hFE01, 16'h0000, 4'b0000, 0, 0, 16'h4000));
    vecs.push_back(v(1, 0, 16'hFE02, 16'h0000, 4'b0000, 0, 0, 16'h0003));
    vecs.push_back(v(0, 1, 16'hFE00, 16'h0001, 4'b0000, 0, 0, 16'h0003));
    vecs.push_back(v(1, 0, 16'hFE00, 16'h0000, 4'b0000, 0, 0, 16'h0000));
    vecs.push_back(v(1, 0, 16'h0003, 16'h0000, 4'b0100, 1, 0, 16'hC222));
    vecs.push_back(v(1, 0, 16'hFE00, 16'h0000, 4'b0000, 0, 0, 16'h0004));
    vecs.push_back(v(0, 1, 16'h5512, 16'h00AA, 4'b0000, 0, 0, 16'h0004));
    vecs.push_back(v(1, 0, 16'hFE00, 16'h0000, 4'b0000, 0, 0, 16'h0006));
    vecs.push_back(v(1, 0, 16'hFE01, 16'h0000, 4'b0000, 0, 0, 16'h5512));
    vecs.push_back(v(0, 1, 16'hFE00, 16'h0007, 4'b0000, 0, 0, 16'h5512));
    vecs.push_back(v(1, 0, 16'hFE00, 16'h0000, 4'b0000, 0, 0, 16'h0000));
    vecs.push_back(v(1, 0, 16'hFE05, 16'h0000, 4'b0000, 0, 0, 16'h0000));
    vecs.push_back(v(0, 1, 16'hFE05, 16'hFFFF, 4'b0000, 0, 0, 16'h0000));
    vecs.push_back(v(1, 0, 16'hFE03, 16'h0000, 4'b0000, 0, 0, 16'h000F));
    vecs.push_back(v(0, 1, 16'hFE03, 16'h000E, 4'b0000, 0, 0, 16'h000F));
    vecs.push_back(v(1, 0, 16'hFE03, 16'h0000, 4'b0000, 0, 0, 16'h000E));
    vecs.push_back(v(0, 1, 16'h9900, 16'hABCD, 4'b0000, 0, 0, 16'h000E));
    vecs.push_back(v(1, 0, 16'h9901, 16'h0000, 4'b0000, 0, 0, 16'h0000));
    vecs.push_back(v(1, 0, 16'hFE00, 16'h0000, 4'b0000, 0, 0, 16'h0003));
    vecs.push_back(v(1, 0, 16'hFE01, 16'h0000, 4'b0000, 0, 0, 16'h9901));
    vecs.push_back(v(1, 0, 16'hFE02, 16'h0000, 4'b0000, 0, 0, 16'h0004));
    vecs.push_back(v(0, 1, 16'hFE03, 16'h000F, 4'b0000, 0, 0, 16'h0004));
    vecs.push_back(v(0, 1, 16'hFE00, 16'h0007, 4'b0000, 0, 0, 16'h0004));
    vecs.push_back(v(1, 1, 16'h7700, 16'h1111, 4'b0010, 1, 1, 16'hBEEF));
    vecs.push_back(v(1, 0, 16'hFE02, 16'h0000, 4'b0000, 0, 0, 16'h0005));
    vecs.push_back(v(1, 0, 16'hFE00, 16'h0000, 4'b0000, 0, 0, 16'h0000));

    foreach (vecs[k]) begin
      do_op(vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].data,
            cs, prd, pwr, pa, pdin, dn);
      chk("per_cs",   k, {12'b0, cs},  {12'b0, vecs[k].e_cs});
      chk("per_rd",   k, {15'b0, prd}, {15'b0, vecs[k].e_prd});
      chk("per_wr",   k, {15'b0, pwr}, {15'b0, vecs[k].e_pwr});
      chk("per_addr", k, {12'b0, pa},  {12'b0, vecs[k].addr[3:0]});
      chk("per_din",  k, pdin,         vecs[k].data);
      chk("din",      k, dn,           vecs[k].e_din);
    end

    // ACCCNT saturation: clear, preload to FFFE with a held strobe, then 3 more.
    op_chk("cnt_clr", 0, 1'b0, 1'b1, 16'hFE02, 16'h0000, 16'h0000);
    op_chk("cnt_rd0", 0, 1'b1, 1'b0, 16'hFE02, 16'h0000, 16'h0000);
    @(negedge clk);
    rd = 1'b1; addr = 16'h7700;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    rd = 1'b0;
    op_chk("cnt_pre", 0, 1'b1, 1'b0, 16'hFE02, 16'h0000, 16'hFFFE);
    for (int n = 0; n < 3; n++)
      op_chk("cnt_acc", n, 1'b1, 1'b0, 16'h9900, 16'h0000, 16'hA000);
    op_chk("cnt_sat", 0, 1'b1, 1'b0, 16'hFE02, 16'h0000, 16'hFFFF);
    op_chk("cnt_wclr", 0, 1'b0, 1'b1, 16'hFE02, 16'h1234, 16'hFFFF);
    op_chk("cnt_zero", 0, 1'b1, 1'b0, 16'hFE02, 16'h0000, 16'h0000);

    // Reset in the middle of a read with every status register disturbed.
    op_chk("pre_err", 0, 1'b1, 1'b0, 16'h4000, 16'h0000, 16'h0000);
    op_chk("pre_msk", 0, 1'b0, 1'b1, 16'hFE03, 16'h000E, 16'h0000);
    op_chk("pre_rd",  0, 1'b1, 1'b0, 16'h7705, 16'h0000, 16'hBEEF);
    @(negedge clk);
    rst = 1'b1; rd = 1'b1; addr = 16'h7700;
    #1;
    chk("mid_per_rd", 0, {15'b0, per_rd}, 16'h0000);
    @(negedge clk);
    rst = 1'b0; rd = 1'b0;
    #1;
    chk("mid_din", 0, din, 16'h0000);
    op_chk("post_err", 0, 1'b1, 1'b0, 16'hFE00, 16'h0000, 16'h0000);
    op_chk("post_bad", 0, 1'b1, 1'b0, 16'hFE01, 16'h0000, 16'h0000);
    op_chk("post_cnt", 0, 1'b1, 1'b0, 16'hFE02, 16'h0000, 16'h0000);
    op_chk("post_msk", 0, 1'b1, 1'b0, 16'hFE03, 16'h0000, 16'h000F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
